// File: rtl/sobel_edge.sv
// sobel_edge: streaming 3x3 Sobel gradient magnitude and thresholded edge flag over a square raster.
// Ports:
//   clk_i         rising-edge clock
//   reset_i       synchronous active-high reset (wins over a simultaneous in_valid_i)
//   in_valid_i    input pixel qualifier, no backpressure, arbitrary gaps allowed
//   din_i         8-bit unsigned pixel in raster order
//   out_valid_o   dout_o/edge_o carry an interior result this cycle
//   dout_o        min(|Gx|+|Gy|, 255), held while out_valid_o is low
//   edge_o        |Gx|+|Gy| >= THRESH on the unsaturated magnitude, held while out_valid_o is low
//   frame_done_o  one-cycle pulse coincident with the last result of a frame
module sobel_edge #(
    parameter int WIDTH  = 128,
    parameter int THRESH = 128
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       in_valid_i,
    input  logic [7:0] din_i,
    output logic       out_valid_o,
    output logic [7:0] dout_o,
    output logic       edge_o,
    output logic       frame_done_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d, row_q, row_d;
    logic [7:0]      lb1_q [WIDTH];
    logic [7:0]      lb2_q [WIDTH];
    logic [7:0]      wa_q [3];
    logic [7:0]      wb_q [3];
    logic [7:0]      nc [3];
    logic            accept, interior, last_px;
    logic signed [10:0] gx, gy;
    logic [10:0]     mag;
    logic            out_valid_q, edge_q;
    logic [7:0]      dout_q;

    // 1-2-1 weighted sum of three taps, at most 1020
    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {2'b0, a} + {1'b0, b, 1'b0} + {2'b0, c};
    endfunction

    assign accept   = in_valid_i && !reset_i;
    assign interior = col_q >= CW'(2) && row_q >= CW'(2);

    // Window columns: wa_q is j=0, wb_q is j=1, and the incoming column nc is j=2,
    // so the result for this accept is computed before the window shifts.
    always_comb begin
        nc[0] = lb2_q[col_q];
        nc[1] = lb1_q[col_q];
        nc[2] = din_i;
    end

    assign gx  = $signed({1'b0, wsum(nc[0], nc[1], nc[2])}) - $signed({1'b0, wsum(wa_q[0], wa_q[1], wa_q[2])});
    assign gy  = $signed({1'b0, wsum(wa_q[2], wb_q[2], nc[2])}) - $signed({1'b0, wsum(wa_q[0], wb_q[0], nc[0])});
    assign mag = $unsigned(gx[10] ? -gx : gx) + $unsigned(gy[10] ? -gy : gy);

    // Counters run on every accepted pixel and wrap to (0,0) after the last one,
    // so IDLE and DONE see zero counters and a pixel in DONE starts the next frame.
    always_comb begin
        last_px = col_q == LAST && row_q == LAST;
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        if (in_valid_i) begin
            col_d   = col_q == LAST ? '0 : col_q + 1'b1;
            row_d   = col_q == LAST ? (row_q == LAST ? '0 : row_q + 1'b1) : row_q;
            state_d = last_px ? DONE : STREAM;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // Storage without reset: stale taps are always overwritten before the first
    // interior result of a frame.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb1_q[col_q] <= din_i;
            lb2_q[col_q] <= lb1_q[col_q];
            for (int i = 0; i < 3; i++) begin
                wa_q[i] <= wb_q[i];
                wb_q[i] <= nc[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            edge_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= in_valid_i && interior;
            if (in_valid_i && interior) begin
                dout_q <= mag > 11'd255 ? 8'hff : mag[7:0];
                edge_q <= mag >= 11'(THRESH);
            end
        end
    end

    assign out_valid_o  = out_valid_q;
    assign dout_o       = dout_q;
    assign edge_o       = edge_q;
    assign frame_done_o = state_q == DONE;
endmodule

// File: tb/tb_sobel_edge.sv
// tb_sobel_edge: directed-image bench for sobel_edge on a reduced 32x32 frame.
module tb_sobel_edge;
    localparam int W    = 32;
    localparam int TH   = 64;
    localparam int NOUT = (W - 2) * (W - 2);

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       in_valid_i = 1'b0;
    logic [7:0] din_i = '0;
    logic       out_valid_o, edge_o, frame_done_o;
    logic [7:0] dout_o;

    int n_cmp = 0;
    int n_err = 0;
    int img  [W][W];
    int got  [W][W];
    int gote [W][W];
    int exp_dout = 0;
    int exp_edge = 0;
    int n_out = 0;

    always #5 clk_i = ~clk_i;

    sobel_edge #(.WIDTH(W), .THRESH(TH)) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .in_valid_i(in_valid_i),
        .din_i(din_i),
        .out_valid_o(out_valid_o),
        .dout_o(dout_o),
        .edge_o(edge_o),
        .frame_done_o(frame_done_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference Sobel on the stored image, center (x,y)
    function automatic int mag_at(input int x, input int y);
        int gx = 0;
        int gy = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                gx += img[y-1+i][x-1+j] * (j - 1) * (i == 1 ? 2 : 1);
                gy += img[y-1+i][x-1+j] * (i - 1) * (j == 1 ? 2 : 1);
            end
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    task automatic fill(input int p);
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++)
                case (p)
                    0: img[y][x] = 100;
                    1: img[y][x] = x;
                    2: img[y][x] = x < W / 2 ? 0 : 200;
                    3: img[y][x] = x < W / 2 ? 0 : 16;
                    4: img[y][x] = (x == 10 && y == 10) ? 40 : 0;
                    default: img[y][x] = int'($urandom_range(255));
                endcase
    endtask

    task automatic idle_cycle();
        in_valid_i = 1'b0;
        din_i = 8'($urandom);
        @(posedge clk_i);
        #1;
        check("idle_valid", 32'(out_valid_o), 0);
        check("idle_done", 32'(frame_done_o), 0);
        check("hold_dout", 32'(dout_o), exp_dout);
        check("hold_edge", 32'(edge_o), exp_edge);
    endtask

    task automatic push(input int x, input int y);
        int m;
        in_valid_i = 1'b1;
        din_i = 8'(img[y][x]);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        if (x >= 2 && y >= 2) begin
            m = mag_at(x - 1, y - 1);
            exp_dout = m > 255 ? 255 : m;
            exp_edge = m >= TH ? 1 : 0;
            got[y-1][x-1]  = int'(dout_o);
            gote[y-1][x-1] = int'(edge_o);
            n_out += int'(out_valid_o);
            check("out_valid", 32'(out_valid_o), 1);
            check("dout", 32'(dout_o), exp_dout);
            check("edge", 32'(edge_o), exp_edge);
        end else begin
            check("border_valid", 32'(out_valid_o), 0);
        end
        check("frame_done", 32'(frame_done_o), (x == W - 1 && y == W - 1) ? 1 : 0);
    endtask

    task automatic send_frame(input int duty);
        n_out = 0;
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++) begin
                while (int'($urandom_range(99)) >= duty) idle_cycle();
                push(x, y);
            end
        check("n_out", n_out, NOUT);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        check("rst_valid", 32'(out_valid_o), 0);
        check("rst_dout", 32'(dout_o), 0);
        check("rst_edge", 32'(edge_o), 0);
        check("rst_done", 32'(frame_done_o), 0);
        idle_cycle();

        // Back-to-back frames: each (0,0) arrives during the previous DONE cycle
        fill(0); send_frame(100);
        check("flat_dout", got[5][5], 0);
        check("flat_edge", gote[5][5], 0);
        fill(1); send_frame(100);
        check("ramp_dout", got[7][20], 8);
        check("ramp_edge", gote[7][20], 0);
        fill(2); send_frame(100);
        check("step_l_dout", got[5][15], 255);
        check("step_l_edge", gote[5][15], 1);
        check("step_r_dout", got[5][16], 255);
        check("step_flatl", got[5][14], 0);
        check("step_flatr", got[5][17], 0);
        fill(3); send_frame(100);
        check("thr_eq_dout", got[5][15], 64);
        check("thr_eq_edge", gote[5][15], 1);
        fill(4); send_frame(100);
        check("imp_nw_dout", got[9][9], 80);
        check("imp_nw_edge", gote[9][9], 1);
        check("imp_s_dout", got[11][10], 80);
        check("imp_c_dout", got[10][10], 0);
        check("imp_c_edge", gote[10][10], 0);
        check("imp_far", got[12][12], 0);

        repeat (3) idle_cycle();
        fill(5); send_frame(30);

        // Partial frame, then reset with a coincident pixel that must be dropped
        fill(5);
        for (int k = 0; k < 500; k++) push(k % W, k / W);
        reset_i = 1'b1;
        in_valid_i = 1'b1;
        din_i = 8'hff;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        in_valid_i = 1'b0;
        exp_dout = 0;
        exp_edge = 0;
        check("mid_rst_valid", 32'(out_valid_o), 0);
        check("mid_rst_dout", 32'(dout_o), 0);
        check("mid_rst_done", 32'(frame_done_o), 0);
        repeat (2) idle_cycle();
        fill(5); send_frame(100);
        repeat (2) idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sobel_edge.md
# sobel_edge

Streaming 3x3 Sobel edge detector that sits directly downstream of the 7x7 median filter. It consumes the filter's 128x128 raster stream of 8-bit median pixels, qualified by `out_valid`, and produces gradient magnitudes plus a thresholded edge bit for the 126x126 interior pixels. It has no backpressure: every pixel presented with `in_valid` is accepted, and every output is emitted without stall.

## Interface
- `WIDTH`, default 128: image width and height in pixels (square frame).
- `THRESH`, default 128: edge threshold, compared against the unsaturated 11-bit magnitude.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset. One clock only; reset is synchronous and active-high.
- `in_valid`  in  1  input pixel qualifier; driven by the median filter's `out_valid`.
- `Din`  in  8  input pixel, unsigned; driven by the median filter's `Dout`.
- `out_valid`  out  1  `Dout`/`edge` hold a valid interior result this cycle.
- `Dout`  out  8  min(|Gx|+|Gy|, 255).
- `edge`  out  1  1 when |Gx|+|Gy| >= THRESH.
- `frame_done`  out  1  single-cycle pulse, coincident with the last `out_valid` of a frame.

## Operation
- **Input order:** raster order, row-major, column `c` = 0..127 and row `r` = 0..127. `in_valid` may have arbitrary gaps.
- **Counters:** 7-bit `col` and `row`, advanced only on accepted pixels.
  - `col` wraps 127->0 and increments `row`.
  - `row` wraps 127->0 at end of frame.
- **Line buffers:** two 128x8 buffers hold rows r-1 and r-2. They are written/shifted only on `in_valid`.
- **Window:** 3x3 register window `w[i][j]`; `i` = 0 is the oldest row, `j` = 0 is the leftmost column.
  - Each accepted pixel shifts a new column in: {linebuf2[c], linebuf1[c], Din}.
- **Output rule:** an output is produced when the accepted pixel has c>=2 and r>=2. It is for center (c-1, r-1). Exactly 126x126 = 15876 outputs per frame; no border outputs.
- **Arithmetic:**
  - Gx = (w02+2w12+w22) - (w00+2w10+w20).
  - Gy = (w20+2w21+w22) - (w00+2w01+w02).
  - Each is signed 11-bit, range ±1020.
  - mag = |Gx|+|Gy|, unsigned 11-bit, 0..2040.
  - `Dout` saturates at 255. `edge` uses the full `mag`.
- **State machine:**
  - IDLE: counters 0. The first `in_valid` goes to STREAM, and that pixel is accepted as (0,0).
  - STREAM: accept pixels. Acceptance of (127,127) goes to DONE.
  - DONE: one cycle. `frame_done`=1 and counters are 0. Next state is IDLE.
  - An `in_valid` during DONE is accepted as pixel (0,0) of the next frame, and the state goes straight to STREAM.
- **Frame independence:** stale line-buffer or window contents never reach an output. By the first output of a frame, all nine taps belong to the current frame, so no buffer clearing is required.

## Timing
- **Reset values:** `out_valid`=0, `Dout`=0, `edge`=0, `frame_done`=0, state IDLE, `col`=`row`=0. Line buffers and window are not reset.
- **Latency:** 1 cycle. Pixel accepted at edge N gives `out_valid` high in cycle N+1 with registered `Dout`/`edge`.
- **Throughput:** back-to-back `in_valid` yields back-to-back `out_valid`, one result per accepted interior pixel.
- **Hold behaviour:**
  - `out_valid` is low in any cycle not immediately following a qualifying accept.
  - `Dout`/`edge` hold their last value when `out_valid`=0.
- **`frame_done` timing:** asserted in the same cycle as the `out_valid` for center (126,126).
- **Reset mid-frame:** the partial frame is discarded. No further `out_valid` until the new frame reaches r>=2, c>=2. The next frame starts at (0,0).
- **Reset precedence:** `reset` takes precedence over a simultaneous `in_valid`; that pixel is dropped.

## Test plan
- **Flat image:** all pixels 100, continuous `in_valid` -> 15876 outputs, all `Dout`=0 and `edge`=0; one `frame_done`, on the last output.
- **Horizontal ramp:** pixel = c -> every output has Gx=8, Gy=0, so `Dout`=8 and `edge`=0.
- **Vertical step:** c<64 is 0, c>=64 is 200 -> centers at c=63 and c=64 have mag=800, so `Dout`=255 and `edge`=1. All other centers give 0.
- **Impulse:** value 40 at (10,10), else 0, THRESH=64 -> all 8 neighbours of (10,10) have `Dout`=80 and `edge`=1. Center (10,10) and all others give 0.
- **Throttled input:** random 30% `in_valid` duty on a random image -> results identical to the golden model, exactly 15876 `out_valid`, each 1 cycle after its pixel.
- **Reset recovery:** reset after 5000 pixels, then a full random frame -> no outputs from the discarded data. The new frame gives 15876 outputs matching golden, and the first output comes 1 cycle after pixel (2,2).
